// File: rtl/stm_gain_loader_pkg.sv
// Shared types and default sizes for the STM gain memory writer and reader.
package stm_gain_loader_pkg;

    localparam int STM_DEPTH           = 249;
    localparam int STM_PATTERN_WIDTH   = 13;
    localparam int STM_GAIN_ADDR_WIDTH = 1 + STM_PATTERN_WIDTH + 8;

    typedef struct packed {
        logic [7:0] intensity;
        logic [7:0] phase;
    } stm_gain_word_t;

    typedef enum logic {
        IDLE,
        LOAD
    } loader_state_t;

endpackage

// File: rtl/stm_gain_addr_cnt.sv
// Transducer/pattern index counter for the segmented STM gain memory layout.
// Shared by the writer (loader) and the reader-side index generator.
module stm_gain_addr_cnt
    import stm_gain_loader_pkg::*;
#(
    parameter int DEPTH         = STM_DEPTH,
    parameter int PATTERN_WIDTH = STM_PATTERN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     step,
    input  logic [PATTERN_WIDTH-1:0] last_pat,
    output logic [7:0]               tr_cnt,
    output logic [PATTERN_WIDTH-1:0] pat_cnt,
    output logic                     last
);

    localparam logic [7:0] TR_LAST = 8'(DEPTH - 1);

    logic tr_wrap;

    // Transducer slots DEPTH..255 are padding and are skipped by wrapping early.
    assign tr_wrap = (tr_cnt == TR_LAST);
    assign last    = tr_wrap && (pat_cnt == last_pat);

    // NOTE: state is written with <= so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            tr_cnt  <= '0;
            pat_cnt <= '0;
        end else if (step) begin
            if (tr_wrap) begin
                tr_cnt  <= '0;
                pat_cnt <= pat_cnt + 1'b1;
            end else begin
                tr_cnt  <= tr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stm_gain_loader.sv
// Host-stream writer for the segmented STM gain BRAM: one pipeline stage from
// handshake to BRAM write, with DONE/CYCLE on completion and ERR on reject/abort.
module stm_gain_loader
    import stm_gain_loader_pkg::*;
#(
    parameter int DEPTH         = STM_DEPTH,
    parameter int PATTERN_WIDTH = STM_PATTERN_WIDTH
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          START,
    input  logic                          SEGMENT,
    input  logic [PATTERN_WIDTH:0]        NUM_PATTERNS,
    input  logic                          ABORT,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    input  logic [15:0]                   IN_DATA,
    output logic                          BRAM_WE,
    output logic [PATTERN_WIDTH+8:0]      BRAM_ADDR,
    output logic [15:0]                   BRAM_DIN,
    output logic                          BUSY,
    output logic                          DONE,
    output logic                          ERR,
    output logic [PATTERN_WIDTH-1:0]      CYCLE
);

    localparam logic [PATTERN_WIDTH:0] MAX_PATTERNS = {1'b1, {PATTERN_WIDTH{1'b0}}};

    loader_state_t              state;
    logic                       seg;
    logic [PATTERN_WIDTH-1:0]   last_pat;
    logic [7:0]                 tr_cnt;
    logic [PATTERN_WIDTH-1:0]   pat_cnt;
    logic                       last;
    logic                       start_ok;
    logic                       xfer;
    logic                       accept;
    logic                       step;
    stm_gain_word_t             word;

    assign word     = IN_DATA;
    assign start_ok = (NUM_PATTERNS != '0) && (NUM_PATTERNS <= MAX_PATTERNS);
    assign xfer     = IN_VALID && IN_READY;
    assign accept   = (state == IDLE) && START && start_ok;
    // A word arriving with ABORT is dropped and must not advance the counters.
    assign step     = (state == LOAD) && xfer && !ABORT;

    stm_gain_addr_cnt #(
        .DEPTH         (DEPTH),
        .PATTERN_WIDTH (PATTERN_WIDTH)
    ) u_addr_cnt (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clear    (accept),
        .step     (step),
        .last_pat (last_pat),
        .tr_cnt   (tr_cnt),
        .pat_cnt  (pat_cnt),
        .last     (last)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            seg       <= 1'b0;
            last_pat  <= '0;
            IN_READY  <= 1'b0;
            BUSY      <= 1'b0;
            BRAM_WE   <= 1'b0;
            BRAM_ADDR <= '0;
            BRAM_DIN  <= '0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            CYCLE     <= '0;
        end else begin
            BRAM_WE <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        if (start_ok) begin
                            seg      <= SEGMENT;
                            last_pat <= PATTERN_WIDTH'(NUM_PATTERNS - 1'b1);
                            state    <= LOAD;
                            IN_READY <= 1'b1;
                            BUSY     <= 1'b1;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (ABORT) begin
                        state    <= IDLE;
                        IN_READY <= 1'b0;
                        BUSY     <= 1'b0;
                        ERR      <= 1'b1;
                    end else if (xfer) begin
                        BRAM_WE   <= 1'b1;
                        BRAM_ADDR <= {seg, pat_cnt, tr_cnt};
                        BRAM_DIN  <= word;
                        if (last) begin
                            state    <= IDLE;
                            IN_READY <= 1'b0;
                            BUSY     <= 1'b0;
                            DONE     <= 1'b1;
                            CYCLE    <= last_pat;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stm_gain_loader.sv
// Directed-sequence bench with random data/valid patterns; expected BRAM writes
// are computed from the segment/pattern/transducer layout with plain arithmetic.
module tb_stm_gain_loader;
    import stm_gain_loader_pkg::*;

    localparam int DEPTH = 249;
    localparam int PW    = 13;
    localparam int AW    = 1 + PW + 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          segment = 1'b0;
    logic [PW:0]   num_patterns = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_data = '0;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [15:0]   bram_din;
    logic          busy;
    logic          done;
    logic          err;
    logic [PW-1:0] cycle;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = -1;
    int last_hs = -1;

    logic [AW-1:0] got_addr[$];
    logic [15:0]   got_data[$];
    logic [AW-1:0] exp_addr[$];
    logic [15:0]   exp_data[$];
    logic [AW-1:0] saved_addr[$];
    logic [15:0]   saved_data[$];
    logic [15:0]   mem[int];

    stm_gain_loader #(.DEPTH(DEPTH), .PATTERN_WIDTH(PW)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .SEGMENT(segment),
        .NUM_PATTERNS(num_patterns), .ABORT(abort), .IN_VALID(in_valid),
        .IN_READY(in_ready), .IN_DATA(in_data), .BRAM_WE(bram_we),
        .BRAM_ADDR(bram_addr), .BRAM_DIN(bram_din), .BUSY(busy), .DONE(done),
        .ERR(err), .CYCLE(cycle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Bus monitor: BRAM image plus the ordered write log, DONE and ERR pulses.
    always @(negedge clk) begin
        if (bram_we) begin
            got_addr.push_back(bram_addr);
            got_data.push_back(bram_din);
            mem[int'(bram_addr)] = bram_din;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        got_addr.delete();
        got_data.delete();
        done_cnt = 0;
        err_cnt  = 0;
        done_cyc = -1;
    endtask

    task automatic pulse_start(input logic s, input int n);
        segment      = s;
        num_patterns = (PW+1)'(n);
        start        = 1'b1;
        tick(1);
        start        = 1'b0;
    endtask

    // Reference layout: segment, then pattern, then transducer 0..DEPTH-1.
    task automatic build_load(input int s, input int n);
        exp_addr.delete();
        exp_data.delete();
        for (int p = 0; p < n; p++) begin
            for (int t = 0; t < DEPTH; t++) begin
                exp_addr.push_back(AW'(s * (1 << (PW + 8)) + p * 256 + t));
                exp_data.push_back(16'($urandom()));
            end
        end
    endtask

    task automatic feed(input int first, input int count, input int pct);
        int  sent = 0;
        int  budget = 0;
        bit  hs;
        while (sent < count && budget < 20000) begin
            in_valid = ($urandom_range(99) < pct);
            in_data  = exp_data[first + sent];
            hs       = in_valid && in_ready;
            tick(1);
            budget++;
            if (hs) begin
                sent++;
                last_hs = cyc;
            end
        end
        in_valid = 1'b0;
        check("feed_budget", 64'(sent), 64'(count));
    endtask

    task automatic check_writes(input string tag, input int n);
        int m;
        check({tag, "_count"}, 64'(got_addr.size()), 64'(n));
        m = (got_addr.size() < n) ? got_addr.size() : n;
        for (int i = 0; i < m; i++) begin
            check({tag, "_addr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
            check({tag, "_data"}, 64'(got_data[i]), 64'(exp_data[i]));
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_flags"}, 64'({in_ready, bram_we, busy, done, err}), 64'(0));
        check({tag, "_addr"}, 64'(bram_addr), 64'(0));
        check({tag, "_din"}, 64'(bram_din), 64'(0));
        check({tag, "_cycle"}, 64'(cycle), 64'(0));
    endtask

    initial begin
        // Reset, then idle with IN_VALID held high: nothing may move.
        in_valid = 1'b1;
        in_data  = 16'($urandom());
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_quiet("reset_idle");
            tick(1);
        end
        in_valid = 1'b0;
        check("reset_no_writes", 64'(got_addr.size()), 64'(0));

        // Full 16-pattern load into segment 0, continuous valid.
        clear_obs();
        build_load(0, 16);
        pulse_start(1'b0, 16);
        check("a_busy", 64'(busy), 64'(1));
        feed(0, 16 * DEPTH, 100);
        tick(3);
        check_writes("a_wr", 16 * DEPTH);
        if (got_addr.size() > 5 * DEPTH + 248)
            check("a_addr_p5_t248", 64'(got_addr[5 * DEPTH + 248]), 64'h05F8);
        check("a_done_cnt", 64'(done_cnt), 64'(1));
        check("a_done_latency", 64'(done_cyc), 64'(last_hs));
        check("a_cycle", 64'(cycle), 64'(15));
        check("a_ready_low", 64'({in_ready, busy}), 64'(0));
        saved_addr = exp_addr;
        saved_data = exp_data;

        // Segment 1, 4 patterns, random valid gaps; a START mid-load is ignored.
        clear_obs();
        build_load(1, 4);
        pulse_start(1'b1, 4);
        feed(0, 500, 50);
        pulse_start(1'b0, 0);
        check("b_busy_after_start", 64'(busy), 64'(1));
        feed(500, 4 * DEPTH - 500, 50);
        tick(3);
        check_writes("b_wr", 4 * DEPTH);
        check("b_done_cnt", 64'(done_cnt), 64'(1));
        check("b_err_cnt", 64'(err_cnt), 64'(0));
        check("b_cycle", 64'(cycle), 64'(3));
        for (int k = 0; k < 8; k++) begin
            int i = $urandom_range(16 * DEPTH - 1);
            check("b_seg0_intact", 64'(mem[int'(saved_addr[i])]), 64'(saved_data[i]));
        end

        // Rejected STARTs, then the largest legal count, and START+ABORT in IDLE.
        clear_obs();
        pulse_start(1'b0, 0);
        tick(1);
        check("c_err_zero", 64'(err_cnt), 64'(1));
        check("c_busy_zero", 64'(busy), 64'(0));
        pulse_start(1'b0, 8193);
        tick(1);
        check("c_err_over", 64'(err_cnt), 64'(2));
        check("c_busy_over", 64'({busy, in_ready}), 64'(0));
        pulse_start(1'b1, 8192);
        check("c_max_accepted", 64'({busy, in_ready}), 64'(3));
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(1);
        check("c_err_abort", 64'(err_cnt), 64'(3));
        segment = 1'b0; num_patterns = 1; start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        check("c_start_wins", 64'(busy), 64'(1));
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(1);
        check("c_err_final", 64'(err_cnt), 64'(4));
        check("c_cycle_kept", 64'(cycle), 64'(3));

        // ABORT after 300 words of a 2-pattern load; the ABORT-cycle word is dropped.
        clear_obs();
        build_load(0, 2);
        pulse_start(1'b0, 2);
        feed(0, 300, 100);
        abort = 1'b1; in_valid = 1'b1; in_data = 16'($urandom());
        tick(1);
        abort = 1'b0; in_valid = 1'b0;
        check("d_ready_low", 64'({in_ready, busy}), 64'(0));
        tick(2);
        check_writes("d_wr", 300);
        check("d_err_cnt", 64'(err_cnt), 64'(1));
        check("d_done_cnt", 64'(done_cnt), 64'(0));
        check("d_cycle_kept", 64'(cycle), 64'(3));

        clear_obs();
        build_load(0, 1);
        pulse_start(1'b0, 1);
        feed(0, DEPTH, 70);
        tick(3);
        check_writes("e_wr", DEPTH);
        check("e_done_cnt", 64'(done_cnt), 64'(1));
        check("e_cycle", 64'(cycle), 64'(0));

        // Reset for one cycle at word 100 of a load, then a fresh load.
        clear_obs();
        build_load(1, 3);
        pulse_start(1'b1, 3);
        feed(0, 100, 100);
        rst_n = 1'b0; in_valid = 1'b1;
        tick(1);
        rst_n = 1'b1; in_valid = 1'b0;
        check_quiet("f_after_reset");
        tick(2);
        check_writes("f_wr", 100);
        check("f_no_pulses", 64'(done_cnt + err_cnt), 64'(0));

        clear_obs();
        build_load(1, 2);
        pulse_start(1'b1, 2);
        check("g_accepted", 64'(busy), 64'(1));
        feed(0, 2 * DEPTH, 60);
        tick(3);
        check_writes("g_wr", 2 * DEPTH);
        check("g_done_cnt", 64'(done_cnt), 64'(1));
        check("g_cycle", 64'(cycle), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
